zigzag_reorder: RTL

ZIGZAG_REORDER -- requirements
Module: zigzag_reorder

---
 rtl/zigzag_reorder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/zigzag_reorder.sv
// Ping-pong 2x64 coefficient buffer: row-major 8x8 blocks in, JPEG zigzag order out.
// Optional ZZ_OVF_DET_EN: ovf becomes a sticky flag for dropped input beats (tied low otherwise).

module zigzag_reorder (
    input  logic        clk,
    input  logic        rstn,
    input  logic [10:0] coef_in,
    input  logic        coef_in_valid,
    output logic [10:0] coef_out,
    output logic        coef_out_valid,
    input  logic        coef_out_ready,
    output logic [5:0]  coef_out_idx,
    output logic        coef_out_eob,
    output logic        ovf
);

    localparam int unsigned CW = 11;
    localparam int unsigned AW = 6;
    localparam int unsigned NB = 64;

    localparam logic [AW-1:0] ZZ [NB] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] mem [2][NB];
    logic          wptr;
    logic          rptr;
    logic [AW-1:0] wcnt;
    logic [AW-1:0] k;
    logic [1:0]    full;

    logic          load;
    logic          last_load;
    logic          wr_ok;
    logic          wr_acc;
    logic          wr_last;
    logic [1:0]    full_nxt;
    logic          rptr_nxt;
    logic [AW-1:0] k_nxt;
    logic [CW-1:0] data_nxt;
    logic          valid_nxt;
    logic [AW-1:0] idx_nxt;
    logic          eob_nxt;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (full[rptr]) state_nxt = SEND;
            SEND:    if (last_load && !full[~rptr]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read side: a beat is fetched whenever the output stage is empty or draining.
    // The bank is released as soon as its last coefficient sits in the output
    // register, so the writer can reuse it with no gap between blocks.
    always_comb begin
        load      = (state == SEND) && (!coef_out_valid || coef_out_ready);
        last_load = load && (k == AW'(NB - 1));
        k_nxt     = k;
        rptr_nxt  = rptr;
        data_nxt  = coef_out;
        valid_nxt = coef_out_valid;
        idx_nxt   = coef_out_idx;
        eob_nxt   = coef_out_eob;
        if (load) begin
            data_nxt  = mem[rptr][ZZ[k]];
            valid_nxt = 1'b1;
            idx_nxt   = k;
            eob_nxt   = last_load;
            k_nxt     = k + AW'(1);
        end else if (coef_out_valid && coef_out_ready) begin
            valid_nxt = 1'b0;
        end
        if (last_load) rptr_nxt = ~rptr;
    end

    // Write side: a full write bank accepts only in the cycle its last entry is read out
    always_comb begin
        wr_ok    = !full[wptr] || (last_load && (wptr == rptr));
        wr_acc   = coef_in_valid && wr_ok;
        wr_last  = wr_acc && (wcnt == AW'(NB - 1));
        full_nxt = full;
        if (last_load) full_nxt[rptr] = 1'b0;
        if (wr_last)   full_nxt[wptr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr           <= 1'b0;
            rptr           <= 1'b0;
            wcnt           <= '0;
            k              <= '0;
            full           <= '0;
            coef_out       <= '0;
            coef_out_valid <= 1'b0;
            coef_out_idx   <= '0;
            coef_out_eob   <= 1'b0;
        end else begin
            if (wr_acc)  wcnt <= wcnt + AW'(1);
            if (wr_last) wptr <= ~wptr;
            rptr           <= rptr_nxt;
            k              <= k_nxt;
            full           <= full_nxt;
            coef_out       <= data_nxt;
            coef_out_valid <= valid_nxt;
            coef_out_idx   <= idx_nxt;
            coef_out_eob   <= eob_nxt;
        end
    end

    // Coefficient storage, not reset
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr][wcnt] <= coef_in;
    end

`ifdef ZZ_OVF_DET_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                       ovf <= 1'b0;
        else if (coef_in_valid && !wr_ok) ovf <= 1'b1;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
